// File: rtl/tetris_pkg.sv
// Shared Tetris datapath types and board geometry.
//   COLS/ROWS : default board size; RW/CW : row/column index widths
//   cell_t    : one piece cell {row, col}
//   sweep_state_e : board clear sweep states
package tetris_pkg;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 20;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned CW   = $clog2(COLS);

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEARING,
        CLEAR_DONE
    } sweep_state_e;

endpackage

// File: rtl/full_row_finder.sv
// Priority encoder over the per-row full flags.
//   full            : one flag per row, bit r = row r is full
//   any_full        : at least one flag set
//   lowest_full_idx : highest-index (lowest on screen) full row, 0 if none
module full_row_finder #(
    parameter  int unsigned ROWS = tetris_pkg::ROWS,
    localparam int unsigned RW   = $clog2(ROWS)
) (
    input  logic [ROWS-1:0] full,
    output logic            any_full,
    output logic [RW-1:0]   lowest_full_idx
);

    // Ascending scan: the last hit is the highest index.
    always_comb begin
        any_full        = |full;
        lowest_full_idx = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (full[r]) begin
                lowest_full_idx = RW'(r);
            end
        end
    end

endmodule

// File: rtl/line_clear.sv
// Playfield storage and row-removal engine.
//   clk, reset     : clock, synchronous active-high reset
//   start          : zero lines_cleared
//   transform_en   : OR the four cells (cell_row/cell_col) into the board
//   remove_en      : drop the lowest full row, shifting rows above it down
//   clear_en       : sweep the board to zero, one row per cycle
//   remove         : a full row exists (combinational)
//   game_over      : row 0 occupied (combinational)
//   done           : clear sweep finished (registered)
//   board          : flattened board, bit r*COLS+c = row r, column c
//   lines_cleared  : rows removed since reset/start, wraps at 16 bits
module line_clear #(
    parameter  int unsigned COLS = tetris_pkg::COLS,
    parameter  int unsigned ROWS = tetris_pkg::ROWS,
    localparam int unsigned RW   = $clog2(ROWS),
    localparam int unsigned CW   = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 transform_en,
    input  logic [4*RW-1:0]      cell_row,
    input  logic [4*CW-1:0]      cell_col,
    input  logic                 remove_en,
    input  logic                 clear_en,
    output logic                 remove,
    output logic                 game_over,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board,
    output logic [15:0]          lines_cleared
);

    import tetris_pkg::sweep_state_e;
    import tetris_pkg::IDLE;
    import tetris_pkg::CLEARING;
    import tetris_pkg::CLEAR_DONE;

    localparam int unsigned NCELLS   = 4;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [COLS-1:0] rows_q [ROWS];
    logic [COLS-1:0] rows_d [ROWS];
    logic [ROWS-1:0] full;
    logic            any_full;
    logic [RW-1:0]   lowest_full_idx;

    sweep_state_e    state_q, state_d;
    logic [RW-1:0]   ptr_q, ptr_d;
    logic            clear_row_en;
    logic [RW-1:0]   clear_row_idx;
    logic            do_remove;
    logic            do_transform;
    logic [RW-1:0]   cell_r;
    logic [CW-1:0]   cell_c;

    // Per-row full flags and board flattening.
    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign full[r]                 = &rows_q[r];
        assign board[r*COLS +: COLS]   = rows_q[r];
    end

    full_row_finder #(.ROWS(ROWS)) u_finder (
        .full            (full),
        .any_full        (any_full),
        .lowest_full_idx (lowest_full_idx)
    );

    assign remove    = any_full;
    assign game_over = |rows_q[0];

    // Sweep FSM and command arbitration; remove/transform only act in IDLE.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        clear_row_en  = 1'b0;
        clear_row_idx = '0;
        do_remove     = 1'b0;
        do_transform  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_en) begin
                    clear_row_en  = 1'b1;
                    clear_row_idx = '0;
                    ptr_d         = RW'(1);
                    state_d       = CLEARING;
                end else if (remove_en) begin
                    // remove_en outranks transform_en even when it is a no-op
                    do_remove = any_full;
                end else begin
                    do_transform = transform_en;
                end
            end
            CLEARING: begin
                if (!clear_en) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    clear_row_en  = 1'b1;
                    clear_row_idx = ptr_q;
                    if (ptr_q == LAST_ROW) begin
                        state_d = CLEAR_DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + RW'(1);
                    end
                end
            end
            CLEAR_DONE: begin
                if (!clear_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Next board contents.
    always_comb begin
        rows_d = rows_q;
        cell_r = '0;
        cell_c = '0;
        if (do_remove) begin
            // rows at or above the removed row move down by one
            for (int unsigned r = 1; r < ROWS; r++) begin
                if (RW'(r) <= lowest_full_idx) begin
                    rows_d[r] = rows_q[RW'(r - 1)];
                end
            end
            rows_d[0] = '0;
        end else if (do_transform) begin
            for (int unsigned i = 0; i < NCELLS; i++) begin
                cell_r = cell_row[i*RW +: RW];
                cell_c = cell_col[i*CW +: CW];
                if ((32'(cell_r) < ROWS) && (32'(cell_c) < COLS)) begin
                    rows_d[cell_r][cell_c] = 1'b1;
                end
            end
        end
        if (clear_row_en) begin
            rows_d[clear_row_idx] = '0;
        end
    end

    // State, board and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q        <= '{default: '0};
            state_q       <= IDLE;
            ptr_q         <= '0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            rows_q  <= rows_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done    <= (state_d == CLEAR_DONE);
            if (start) begin
                lines_cleared <= '0;
            end else if (do_remove) begin
                lines_cleared <= lines_cleared + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: directed scenarios plus a randomized
// run, all compared against a cell-array reference model.
module tb_line_clear;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 20;
    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 4;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 transform_en;
    logic [4*RW-1:0]      cell_row;
    logic [4*CW-1:0]      cell_col;
    logic                 remove_en;
    logic                 clear_en;
    logic                 remove;
    logic                 game_over;
    logic                 done;
    logic [ROWS*COLS-1:0] board;
    logic [15:0]          lines_cleared;

    line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .transform_en  (transform_en),
        .cell_row      (cell_row),
        .cell_col      (cell_col),
        .remove_en     (remove_en),
        .clear_en      (clear_en),
        .remove        (remove),
        .game_over     (game_over),
        .done          (done),
        .board         (board),
        .lines_cleared (lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: plain cell array, line counter, and the number of
    // consecutive cycles clear_en has been held.
    bit          m_b [ROWS][COLS];
    int unsigned m_lines;
    int          m_hold;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic bit row_full(input int r);
        for (int c = 0; c < COLS; c++) if (!m_b[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [255:0] model_vec();
        logic [255:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[r*COLS + c] = m_b[r][c];
        return v;
    endfunction

    function automatic logic [COLS-1:0] dut_row(input int r);
        return board[r*COLS +: COLS];
    endfunction

    task automatic model_step();
        int f;
        int rr, cc;
        if (reset) begin
            for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_b[r][c] = 1'b0;
            m_lines = 0;
            m_hold  = 0;
            return;
        end
        if (start) m_lines = 0;
        if (clear_en) begin
            if (m_hold < ROWS) for (int c = 0; c < COLS; c++) m_b[m_hold][c] = 1'b0;
            if (m_hold <= ROWS) m_hold++;
        end else if (m_hold != 0) begin
            // sweep just ended or was abandoned: board commands are ignored
            m_hold = 0;
        end else if (remove_en) begin
            f = -1;
            for (int r = 0; r < ROWS; r++) if (row_full(r)) f = r;
            if (f >= 0) begin
                for (int r = f; r > 0; r--) m_b[r] = m_b[r-1];
                for (int c = 0; c < COLS; c++) m_b[0][c] = 1'b0;
                if (!start) m_lines = (m_lines + 1) % 65536;
            end
        end else if (transform_en) begin
            for (int i = 0; i < 4; i++) begin
                rr = int'(cell_row[i*RW +: RW]);
                cc = int'(cell_col[i*CW +: CW]);
                if (rr < ROWS && cc < COLS) m_b[rr][cc] = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        bit any_f, row0;
        @(posedge clk);
        model_step();
        #1;
        any_f = 1'b0;
        row0  = 1'b0;
        for (int r = 0; r < ROWS; r++) if (row_full(r)) any_f = 1'b1;
        for (int c = 0; c < COLS; c++) if (m_b[0][c]) row0 = 1'b1;
        chk("board", 256'(board), model_vec());
        chk("remove", 256'(remove), 256'(any_f));
        chk("game_over", 256'(game_over), 256'(row0));
        chk("done", 256'(done), 256'(m_hold >= ROWS));
        chk("lines_cleared", 256'(lines_cleared), 256'(m_lines));
    endtask

    task automatic set_cells(input int r0, c0, r1, c1, r2, c2, r3, c3);
        cell_row = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
        cell_col = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endtask

    task automatic commit(input int r0, c0, r1, c1, r2, c2, r3, c3);
        set_cells(r0, c0, r1, c1, r2, c2, r3, c3);
        transform_en = 1'b1;
        step();
        transform_en = 1'b0;
    endtask

    task automatic fill_row(input int r);
        commit(r, 0, r, 1, r, 2, r, 3);
        commit(r, 4, r, 5, r, 6, r, 7);
        commit(r, 8, r, 9, r, 9, r, 9);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [149:0] ones150;
    int           burst;

    initial begin
        reset = 1'b1; start = 1'b0; transform_en = 1'b0; remove_en = 1'b0; clear_en = 1'b0;
        cell_row = '0; cell_col = '0;
        m_lines = 0; m_hold = 0;
        ones150 = '1;
        step();
        step();
        reset = 1'b0;
        chk("rst_board", 256'(board), 256'(0));
        chk("rst_lines", 256'(lines_cleared), 256'(0));
        chk("rst_done", 256'(done), 256'(0));

        // Bottom-row piece
        commit(19, 0, 19, 1, 19, 2, 19, 3);
        chk("piece_bits", 256'(board[193:190]), 256'(4'hF));
        chk("piece_remove", 256'(remove), 256'(0));
        chk("piece_game_over", 256'(game_over), 256'(0));

        // Two full rows with a single cell above them
        commit(19, 4, 19, 5, 19, 6, 19, 7);
        commit(19, 8, 19, 9, 19, 9, 19, 9);
        fill_row(18);
        commit(17, 0, 17, 0, 17, 0, 17, 0);
        chk("two_full_remove", 256'(remove), 256'(1));
        remove_en = 1'b1;
        step();
        chk("rm1_row19", 256'(dut_row(19)), 256'(10'h3FF));
        chk("rm1_row18", 256'(dut_row(18)), 256'(10'h001));
        chk("rm1_lines", 256'(lines_cleared), 256'(1));
        step();
        remove_en = 1'b0;
        chk("rm2_remove", 256'(remove), 256'(0));
        chk("rm2_row19", 256'(dut_row(19)), 256'(10'h001));
        chk("rm2_lines", 256'(lines_cleared), 256'(2));

        // Top-row cell, then a remove with nothing full
        commit(0, 5, 0, 5, 0, 5, 0, 5);
        chk("top_game_over", 256'(game_over), 256'(1));
        remove_en = 1'b1;
        step();
        remove_en = 1'b0;
        chk("noop_lines", 256'(lines_cleared), 256'(2));
        chk("noop_row0", 256'(dut_row(0)), 256'(10'h020));
        chk("noop_row19", 256'(dut_row(19)), 256'(10'h001));

        // Full sweep on a full board
        for (int r = 0; r < ROWS; r++) fill_row(r);
        chk("full_board", 256'(board), {56'h0, 200'h0} | {ones150, 50'h3FFFFFFFFFFFF});
        clear_en = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            step();
            if (k == ROWS - 2) chk("sweep_done_early", 256'(done), 256'(0));
        end
        chk("sweep_board", 256'(board), 256'(0));
        chk("sweep_done", 256'(done), 256'(1));
        step();
        chk("sweep_done_hold", 256'(done), 256'(1));
        clear_en = 1'b0;
        step();
        chk("sweep_done_fall", 256'(done), 256'(0));

        // Sweep abandoned after five cycles
        for (int r = 0; r < ROWS; r++) fill_row(r);
        clear_en = 1'b1;
        repeat (5) step();
        clear_en = 1'b0;
        repeat (4) begin
            step();
            chk("abort_done", 256'(done), 256'(0));
        end
        chk("abort_top", 256'(board[49:0]), 256'(0));
        chk("abort_bottom", 256'(board[199:50]), 256'(ones150));

        // remove_en beats transform_en; start beats the increment
        do_reset();
        fill_row(19);
        commit(18, 0, 18, 0, 18, 0, 18, 0);
        set_cells(10, 3, 10, 3, 10, 3, 10, 3);
        remove_en = 1'b1;
        transform_en = 1'b1;
        step();
        remove_en = 1'b0;
        transform_en = 1'b0;
        chk("prio_row10", 256'(dut_row(10)), 256'(0));
        chk("prio_row19", 256'(dut_row(19)), 256'(10'h001));
        chk("prio_lines", 256'(lines_cleared), 256'(1));
        fill_row(18);
        start = 1'b1;
        remove_en = 1'b1;
        step();
        start = 1'b0;
        remove_en = 1'b0;
        chk("start_lines", 256'(lines_cleared), 256'(0));
        chk("start_row19", 256'(dut_row(19)), 256'(10'h001));

        // Randomized traffic
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) == 0);
            if (burst > 0) begin
                clear_en = 1'b1;
                burst--;
            end else begin
                clear_en = 1'b0;
                if ($urandom_range(0, 79) == 0) burst = $urandom_range(2, 30);
            end
            remove_en    = ($urandom_range(0, 2) == 0);
            transform_en = ($urandom_range(0, 1) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0)      cell_row[i*RW +: RW] = 5'($urandom_range(20, 31));
                else if ($urandom_range(0, 4) == 0) cell_row[i*RW +: RW] = 5'($urandom_range(0, 19));
                else                                cell_row[i*RW +: RW] = 5'($urandom_range(14, 19));
                if ($urandom_range(0, 9) == 0)      cell_col[i*CW +: CW] = 4'($urandom_range(10, 15));
                else                                cell_col[i*CW +: CW] = 4'($urandom_range(0, 9));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
